switch_ingress_router: RTL and testbench
========================================

Name: switch_ingress_router

Overview:
- Per-ingress-port framing and routing FSM for the simple switch; generalises the single-port ingress FSM to NUM_PORTS egress ports.
- Detects SOF, matches the address byte against all egress port addresses and steers the payload to the matched port's FIFO as a one-hot write strobe.
- Replaces the external watchdog with an internal SOF timeout counter.
- Adds drop/abort accounting.

Parameters:
- W_WIDTH, 8, data byte width.
- NUM_PORTS, 4, number of egress ports (1..16).
- SOF_BYTE, 8'hFF, start-of-frame delimiter value.
- SOF_TIMEOUT, 16, maximum consecutive non-SOF cycles tolerated in SOF hunt (>=1).
- CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- sw_en  in  1  frame-valid; low for >=1 cycle between packets.
- data_in  in  W_WIDTH  ingress byte, sampled on posedge clk.
- port_addr  in  NUM_PORTS*W_WIDTH  flattened addresses; port i at [i*W_WIDTH +: W_WIDTH].
- port_busy  in  NUM_PORTS  per-port egress FIFO busy/full.
- drop_cnt_clr  in  1  synchronous clear of drop_cnt.
- wr_en  out  NUM_PORTS  one-hot write strobe to egress FIFOs.
- data_out  out  W_WIDTH  registered payload byte, valid when wr_en != 0.
- eop  out  1  one-cycle pulse, packet delivered completely.
- abort  out  1  one-cycle pulse, packet truncated by mid-packet busy.
- sof_timeout  out  1  one-cycle pulse, SOF hunt timed out.
- drop_cnt  out  CNT_WIDTH  saturating count of dropped packets.

Behaviour:
- Reset and clock:
  - Reset rst_n, asynchronous, active-low; clock clk.
  - Reset values: state IDLE, all outputs 0, sel and timer 0.
  - Reset mid-packet clears immediately; no eop or abort is generated.
- General timing: all outputs registered. data_out and wr_en appear one cycle after the data_in byte they carry.
- States: IDLE, SOF, ADDR, LOAD, DROP.
- IDLE:
  - sw_en=1 -> SOF, timer=0.
  - Otherwise stay.
- SOF:
  - sw_en=0 -> IDLE; no count.
  - data_in==SOF_BYTE -> ADDR.
  - Otherwise, if timer==SOF_TIMEOUT-1 -> DROP, sof_timeout pulse, drop_cnt+1.
  - Otherwise timer+1.
- ADDR:
  - sw_en=0 -> IDLE, drop_cnt+1.
  - Match is the lowest index i with port_addr[i]==data_in.
  - No match -> DROP, drop_cnt+1.
  - Match and port_busy[i]=1 -> DROP, drop_cnt+1.
  - Match and not busy -> LOAD, sel=i.
  - The address byte is never written to a FIFO.
- LOAD:
  - sw_en=1 and port_busy[sel]=0 -> wr_en[sel]=1 next cycle, data_out=data_in.
  - sw_en=0 -> IDLE, eop pulse, wr_en=0.
  - port_busy[sel]=1 (with sw_en=1) -> DROP, abort pulse, drop_cnt+1; the current byte is not written.
  - Busy on non-selected ports is ignored.
- DROP:
  - Discard bytes, wr_en=0.
  - sw_en=0 -> IDLE.
- Back-to-back packets: a one-cycle sw_en gap re-arms the FSM (LOAD->IDLE->SOF). eop may coincide with the IDLE cycle.
- wr_en is at most one-hot. wr_en and eop/abort are never high in the same cycle.
- drop_cnt:
  - Saturates at all ones.
  - drop_cnt_clr has priority; clear and increment in the same cycle give 0.
- Timer width is clog2(SOF_TIMEOUT+1).

Test Plan:
- Setup for all scenarios: NUM_PORTS=4, addrs 0x10/0x20/0x30/0x40, SOF_TIMEOUT=4.
- Good packet: sw_en=1, bytes FF,30,A1,A2,A3, then sw_en=0 -> wr_en=4'b0100 for 3 cycles, data_out A1,A2,A3; eop one cycle after A3 strobe; drop_cnt=0.
- Busy at address: port_busy=4'b0010, bytes FF,20,.. -> no wr_en, state DROP until sw_en=0, drop_cnt=1. Repeat with address 0x55 (no match) -> drop_cnt=2.
- Mid-packet abort: bytes FF,10,B1,B2; port_busy[0] rises during B2 -> B1 written only, abort pulse, no eop, drop_cnt+1. port_busy[3] toggling during a port-0 packet has no effect.
- SOF timeout: sw_en=1, bytes 00,00,00,00 -> sof_timeout pulse after 4th byte, drop_cnt+1; a later FF in the same frame is ignored (DROP) until sw_en=0.
- Back-to-back: packet to 0x40, one-cycle sw_en gap, packet to 0x10 -> both fully delivered, wr_en 4'b1000 then 4'b0001, two eop pulses.
- Counter/reset: CNT_WIDTH=2, five drops -> drop_cnt holds 3; drop_cnt_clr -> 0. rst_n low mid-LOAD -> wr_en=0 immediately, no eop.

Source files
------------

// File: rtl/switch_ingress_router.sv
// Ingress framing/routing FSM: hunts SOF, matches the address byte against the egress
// port addresses and steers payload bytes to one egress FIFO, with drop/abort accounting.
module switch_ingress_router #(
  parameter int                 W_WIDTH     = 8,
  parameter int                 NUM_PORTS   = 4,
  parameter logic [W_WIDTH-1:0] SOF_BYTE    = 8'hFF,
  parameter int                 SOF_TIMEOUT = 16,
  parameter int                 CNT_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sw_en,
  input  logic [W_WIDTH-1:0]           data_in,
  input  logic [NUM_PORTS*W_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS-1:0]         port_busy,
  input  logic                         drop_cnt_clr,
  output logic [NUM_PORTS-1:0]         wr_en,
  output logic [W_WIDTH-1:0]           data_out,
  output logic                         eop,
  output logic                         abort,
  output logic                         sof_timeout,
  output logic [CNT_WIDTH-1:0]         drop_cnt
);

  localparam int TMR_W = $clog2(SOF_TIMEOUT + 1);
  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {IDLE, SOF, ADDR, LOAD, DROP} state_t;

  state_t               state, state_next;
  logic [TMR_W-1:0]     timer, timer_next;
  logic [SEL_W-1:0]     sel, sel_next;
  logic [NUM_PORTS-1:0] wr_en_next;
  logic [W_WIDTH-1:0]   data_out_next;
  logic                 eop_next, abort_next, sof_timeout_next;
  logic [CNT_WIDTH-1:0] drop_cnt_next;
  logic                 drop_inc;

  logic [NUM_PORTS-1:0] hit;
  logic                 match_found;
  logic [SEL_W-1:0]     match_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_match
      assign hit[gi] = (port_addr[gi*W_WIDTH +: W_WIDTH] == data_in);
    end
  endgenerate

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        match_found = 1'b1;
        match_idx   = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_next       = state;
    timer_next       = timer;
    sel_next         = sel;
    wr_en_next       = '0;
    data_out_next    = data_out;
    eop_next         = 1'b0;
    abort_next       = 1'b0;
    sof_timeout_next = 1'b0;
    drop_inc         = 1'b0;
    case (state)
      IDLE: begin
        if (sw_en) begin
          state_next = SOF;
          timer_next = '0;
        end
      end
      SOF: begin
        if (!sw_en) begin
          state_next = IDLE;
        end else if (data_in == SOF_BYTE) begin
          state_next = ADDR;
        end else if (timer == TMR_W'(SOF_TIMEOUT - 1)) begin
          state_next       = DROP;
          sof_timeout_next = 1'b1;
          drop_inc         = 1'b1;
        end else begin
          timer_next = timer + TMR_W'(1);
        end
      end
      ADDR: begin
        if (!sw_en) begin
          state_next = IDLE;
          drop_inc   = 1'b1;
        end else if (!match_found || port_busy[match_idx]) begin
          state_next = DROP;
          drop_inc   = 1'b1;
        end else begin
          state_next = LOAD;
          sel_next   = match_idx;
        end
      end
      LOAD: begin
        if (!sw_en) begin
          state_next = IDLE;
          eop_next   = 1'b1;
        end else if (port_busy[sel]) begin
          state_next = DROP;
          abort_next = 1'b1;
          drop_inc   = 1'b1;
        end else begin
          wr_en_next    = NUM_PORTS'(1) << sel;
          data_out_next = data_in;
        end
      end
      DROP: begin
        if (!sw_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear wins over a same-cycle increment; the count sticks at all ones.
  always_comb begin
    drop_cnt_next = drop_cnt;
    if (drop_cnt_clr) drop_cnt_next = '0;
    else if (drop_inc && (drop_cnt != '1)) drop_cnt_next = drop_cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      sel         <= '0;
      wr_en       <= '0;
      data_out    <= '0;
      eop         <= 1'b0;
      abort       <= 1'b0;
      sof_timeout <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      sel         <= sel_next;
      wr_en       <= wr_en_next;
      data_out    <= data_out_next;
      eop         <= eop_next;
      abort       <= abort_next;
      sof_timeout <= sof_timeout_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

endmodule

// File: tb/tb_switch_ingress_router.sv
// Scoreboard bench for switch_ingress_router: a frame-level reference model queues expected
// strobes/pulses, a negedge monitor pops and compares; drop counts checked per frame.
module tb_switch_ingress_router;

  localparam int TO = 4;

  typedef struct packed {
    logic [1:0] kind;  // 0 write, 1 eop, 2 abort, 3 sof timeout
    logic [3:0] wr;
    logic [7:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sw_en = 1'b0;
  logic [7:0]  data_in = '0;
  logic [31:0] port_addr = {8'h40, 8'h30, 8'h20, 8'h10};
  logic [3:0]  port_busy = '0;
  logic        drop_cnt_clr = 1'b0;

  logic [3:0] wr_en, wr_en2;
  logic [7:0] data_out, data_out2;
  logic       eop, eop2, abort, abort2, sof_timeout, sof_timeout2;
  logic [7:0] drop_cnt;
  logic [1:0] drop_cnt2;

  switch_ingress_router #(.W_WIDTH(8), .NUM_PORTS(4), .SOF_BYTE(8'hFF), .SOF_TIMEOUT(TO),
                          .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .sw_en(sw_en), .data_in(data_in), .port_addr(port_addr),
    .port_busy(port_busy), .drop_cnt_clr(drop_cnt_clr), .wr_en(wr_en), .data_out(data_out),
    .eop(eop), .abort(abort), .sof_timeout(sof_timeout), .drop_cnt(drop_cnt));

  switch_ingress_router #(.W_WIDTH(8), .NUM_PORTS(4), .SOF_BYTE(8'hFF), .SOF_TIMEOUT(TO),
                          .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sw_en(sw_en), .data_in(data_in), .port_addr(port_addr),
    .port_busy(port_busy), .drop_cnt_clr(drop_cnt_clr), .wr_en(wr_en2), .data_out(data_out2),
    .eop(eop2), .abort(abort2), .sof_timeout(sof_timeout2), .drop_cnt(drop_cnt2));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];
  logic [7:0] fb[$];
  logic [3:0] fbusy[$];
  logic [7:0] addrs[4] = '{8'h10, 8'h20, 8'h30, 8'h40};
  int cnt8 = 0;
  int cnt2 = 0;

  function automatic ev_t mk_ev(logic [3:0] w, logic [7:0] d, logic e, logic a, logic s);
    ev_t r;
    if (w != 0)  r = '{kind: 2'd0, wr: w, data: d};
    else if (e)  r = '{kind: 2'd1, wr: 4'd0, data: 8'd0};
    else if (a)  r = '{kind: 2'd2, wr: 4'd0, data: 8'd0};
    else         r = '{kind: 2'd3, wr: 4'd0, data: 8'd0};
    return r;
  endfunction

  // Monitor: every output event from either instance must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && ((wr_en != 0) || eop || abort || sof_timeout ||
                  (wr_en2 != 0) || eop2 || abort2 || sof_timeout2)) begin
      ev_t act, act2, e;
      act  = mk_ev(wr_en, data_out, eop, abort, sof_timeout);
      act2 = mk_ev(wr_en2, data_out2, eop2, abort2, sof_timeout2);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event got=%h got2=%h required=none", act, act2);
      end else begin
        e = exp_q.pop_front();
        if (act !== e || act2 !== e) begin
          errors++;
          $display("FAIL event got=%h got2=%h required=%h", act, act2, e);
        end
      end
      checks++;
      if ($countones({|wr_en, eop, abort, sof_timeout}) > 1 || $countones(wr_en) > 1) begin
        errors++;
        $display("FAIL exclusive wr_en=%b eop=%b abort=%b sof_timeout=%b required=single",
                 wr_en, eop, abort, sof_timeout);
      end
    end
  end

  task automatic drive(input logic s, input logic [7:0] d, input logic [3:0] b, input logic c);
    sw_en = s; data_in = d; port_busy = b; drop_cnt_clr = c;
    @(posedge clk); #1;
  endtask

  task automatic check_cnt(input string name);
    checks++;
    if (drop_cnt !== 8'(cnt8) || drop_cnt2 !== 2'(cnt2)) begin
      errors++;
      $display("FAIL %s drop_cnt=%0d/%0d required=%0d/%0d", name, drop_cnt, drop_cnt2, cnt8, cnt2);
    end
  endtask

  // Frame model: byte 0 is the arming cycle, then SOF hunt, address, payload.
  // clr_at: -1 never, -2 random, otherwise the cycle index that pulses drop_cnt_clr.
  task automatic run_frame(input int gap, input int clr_at, input string name);
    int n, j, a, sel, inc_idx;
    bit aborted;
    n = fb.size(); j = -1; inc_idx = -1;
    for (int k = 1; k < n && k <= TO; k++)
      if (fb[k] == 8'hFF) begin j = k; break; end
    if (j < 0) begin
      if (n - 1 >= TO) begin
        exp_q.push_back('{kind: 2'd3, wr: 4'd0, data: 8'd0});
        inc_idx = TO;
      end
    end else begin
      a = j + 1;
      if (a >= n) inc_idx = n;
      else begin
        sel = -1;
        for (int i = 3; i >= 0; i--) if (addrs[i] == fb[a]) sel = i;
        if (sel < 0 || fbusy[a][sel]) inc_idx = a;
        else begin
          aborted = 0;
          for (int k = a + 1; k < n; k++) begin
            if (fbusy[k][sel]) begin
              exp_q.push_back('{kind: 2'd2, wr: 4'd0, data: 8'd0});
              inc_idx = k; aborted = 1; break;
            end
            exp_q.push_back('{kind: 2'd0, wr: 4'(1 << sel), data: fb[k]});
          end
          if (!aborted) exp_q.push_back('{kind: 2'd1, wr: 4'd0, data: 8'd0});
        end
      end
    end
    for (int c = 0; c < n + gap; c++) begin
      logic clr;
      clr = (clr_at == c) || (clr_at == -2 && $urandom_range(0, 15) == 0);
      if (c < n) drive(1'b1, fb[c], fbusy[c], clr);
      else drive(1'b0, 8'($urandom), 4'($urandom), clr);
      if (clr) begin cnt8 = 0; cnt2 = 0; end
      else if (c == inc_idx) begin
        if (cnt8 < 255) cnt8++;
        if (cnt2 < 3) cnt2++;
      end
    end
    check_cnt(name);
  endtask

  task automatic set_frame(input logic [7:0] b[$], input logic [3:0] bz);
    fb = b; fbusy.delete();
    foreach (b[i]) fbusy.push_back(bz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_en !== 0 || data_out !== 0 || eop || abort || sof_timeout || drop_cnt !== 0) begin
      errors++;
      $display("FAIL reset_state wr_en=%b data_out=%h eop=%b abort=%b sto=%b cnt=%0d required=0",
               wr_en, data_out, eop, abort, sof_timeout, drop_cnt);
    end
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 4'h0, 1'b0);

    set_frame('{8'h00, 8'hFF, 8'h30, 8'hA1, 8'hA2, 8'hA3}, 4'h0);
    run_frame(1, -1, "good_packet");
    set_frame('{8'h00, 8'hFF, 8'h20, 8'h11, 8'h22}, 4'b0010);
    run_frame(1, -1, "busy_at_addr");
    set_frame('{8'h00, 8'hFF, 8'h55, 8'h11}, 4'h0);
    run_frame(1, -1, "no_match");
    set_frame('{8'h00, 8'hFF, 8'h10, 8'hB1, 8'hB2}, 4'h0);
    fbusy = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1001};
    run_frame(2, -1, "mid_abort");
    set_frame('{8'h00, 8'hFF, 8'h10, 8'hE1, 8'hE2, 8'hE3}, 4'h0);
    fbusy = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b1000};
    run_frame(1, -1, "busy_other_port");
    set_frame('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h30, 8'h12}, 4'h0);
    run_frame(1, -1, "sof_timeout");
    set_frame('{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h20, 8'h77}, 4'h0);
    run_frame(1, -1, "sof_at_last_hunt");
    set_frame('{8'h00, 8'hFF}, 4'h0);
    run_frame(1, -1, "end_in_addr");
    set_frame('{8'h00, 8'hFF, 8'h40, 8'hC1, 8'hC2}, 4'h0);
    run_frame(1, -1, "b2b_first");
    set_frame('{8'h00, 8'hFF, 8'h10, 8'hD1, 8'hD2, 8'hD3}, 4'h0);
    run_frame(1, -1, "b2b_second");
    for (int i = 0; i < 5; i++) begin
      set_frame('{8'h00, 8'hFF, 8'h55}, 4'h0);
      run_frame(1, -1, "saturate");
    end
    drive(1'b0, 8'h00, 4'h0, 1'b1);
    cnt8 = 0; cnt2 = 0;
    check_cnt("clear");
    set_frame('{8'h00, 8'hFF, 8'h55}, 4'h0);
    run_frame(1, 2, "clear_vs_inc");

    // Reset in the middle of a payload: C1 is delivered, then nothing more.
    set_frame('{8'h00, 8'hFF, 8'h10, 8'hC1}, 4'h0);
    exp_q.push_back('{kind: 2'd0, wr: 4'b0001, data: 8'hC1});
    foreach (fb[i]) drive(1'b1, fb[i], 4'h0, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 0 || eop || abort || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_load wr_en=%b eop=%b abort=%b pending=%0d required=0",
               wr_en, eop, abort, exp_q.size());
    end
    exp_q.delete();
    cnt8 = 0; cnt2 = 0;
    sw_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 4'h0, 1'b0);
    check_cnt("after_reset");

    for (int f = 0; f < 200; f++) begin
      int nh, np, full;
      logic [3:0] bz;
      fb.delete(); fbusy.delete();
      fb.push_back(8'($urandom));
      nh = $urandom_range(0, 5);
      for (int k = 0; k < nh; k++) fb.push_back(8'($urandom_range(0, 254)));
      fb.push_back(8'hFF);
      case ($urandom_range(0, 5))
        0: fb.push_back(8'h55);
        1: fb.push_back(8'h10);
        2: fb.push_back(8'h20);
        3: fb.push_back(8'h30);
        default: fb.push_back(8'h40);
      endcase
      np = $urandom_range(0, 6);
      for (int k = 0; k < np; k++) fb.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        full = fb.size();
        fb = fb[0:$urandom_range(0, full - 1)];
      end
      foreach (fb[i]) begin
        bz = 4'($urandom) & 4'($urandom) & 4'($urandom);
        fbusy.push_back(bz);
      end
      run_frame($urandom_range(1, 3), -2, "random");
    end

    repeat (3) drive(1'b0, 8'h00, 4'h0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=none required=%0d more events", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
